// File: rtl/bittiming_pkg.sv
// Shared encodings and field widths for the bit-timing configuration controller.
package bittiming_pkg;

   localparam int BRP_W_DEFAULT = 6;
   localparam int TSEG1_W       = 4;
   localparam int TSEG2_W       = 3;
   localparam int SJW_W         = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_PEND = 2'd3
   } ctrl_state_t;

endpackage

// File: rtl/bt_prescaler.sv
// Time-quantum counter: one Prescale_EN pulse every brp+1 clocks while running.
module bt_prescaler
   import bittiming_pkg::*;
#(
   parameter int BRP_W = BRP_W_DEFAULT
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             run,
   input  logic [BRP_W-1:0] brp,
   output logic             Prescale_EN
);

   logic [BRP_W-1:0] cnt_r;
   logic             wrap_s;

   assign wrap_s = (cnt_r == brp);

   // Quantum counter: cleared ahead of idle/load, wraps on the active prescaler value
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_r <= {BRP_W{1'b0}};
      end else if (clear) begin
         cnt_r <= {BRP_W{1'b0}};
      end else if (run) begin
         if (wrap_s) begin
            cnt_r <= {BRP_W{1'b0}};
         end else begin
            cnt_r <= cnt_r + BRP_W'(1);
         end
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign Prescale_EN = run & wrap_s;

endmodule

// File: rtl/bittiming_ctrl.sv
// Bit-timing configuration controller: validates writes into a shadow set and applies
// them to the active timing only at a bit boundary (or when the bus is disabled).
module bittiming_ctrl
   import bittiming_pkg::*;
#(
   parameter int BRP_W = BRP_W_DEFAULT
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               enable,
   input  logic               cfg_wr,
   input  logic [BRP_W-1:0]   cfg_brp,
   input  logic [TSEG1_W-1:0] cfg_tseg1,
   input  logic [TSEG2_W-1:0] cfg_tseg2,
   input  logic [SJW_W-1:0]   cfg_sjw,
   input  logic               sendpoint,
   output logic               Prescale_EN,
   output logic [TSEG1_W-1:0] tseg1,
   output logic [TSEG2_W-1:0] tseg2,
   output logic [SJW_W-1:0]   sjw,
   output logic               cfg_valid,
   output logic               cfg_busy,
   output logic               cfg_done,
   output logic               cfg_err,
   output logic [1:0]         ctrl_st
);

   ctrl_state_t        state_r, state_nxt_s;
   logic [BRP_W-1:0]   sh_brp_r, act_brp_r;
   logic [TSEG1_W-1:0] sh_tseg1_r, act_tseg1_r;
   logic [TSEG2_W-1:0] sh_tseg2_r, act_tseg2_r;
   logic [SJW_W-1:0]   sh_sjw_r, act_sjw_r;
   logic               valid_r, done_r, err_r;
   logic               cfg_ok_s, capture_s, reject_s;
   logic               in_run_s, clear_s, pe_s;

   function automatic logic cfg_ok(input logic [TSEG1_W-1:0] t1,
                                   input logic [TSEG2_W-1:0] t2,
                                   input logic [SJW_W-1:0]   sj);
      cfg_ok = (t2 != {TSEG2_W{1'b0}}) && (TSEG2_W'(sj) <= t2) && (t1 >= TSEG1_W'(sj));
   endfunction

   assign cfg_ok_s = cfg_ok(cfg_tseg1, cfg_tseg2, cfg_sjw);

   // Next-state decode with write capture/reject qualification
   always_comb begin
      state_nxt_s = state_r;
      capture_s   = 1'b0;
      reject_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            reject_s = cfg_wr & ~cfg_ok_s;
            if (cfg_wr && cfg_ok_s) begin
               capture_s   = 1'b1;
               state_nxt_s = ST_LOAD;
            end else if (enable && valid_r) begin
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_LOAD: begin
            reject_s = cfg_wr;
            if (enable) begin
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            reject_s = cfg_wr & ~cfg_ok_s;
            if (cfg_wr && cfg_ok_s) begin
               capture_s   = 1'b1;
               // A disabled bus has no bit boundary to wait for
               state_nxt_s = enable ? ST_PEND : ST_LOAD;
            end else if (!enable) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_PEND: begin
            reject_s = cfg_wr;
            if (!enable || (sendpoint && pe_s)) begin
               state_nxt_s = ST_LOAD;
            end else begin
               state_nxt_s = ST_PEND;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // State register and one-cycle status pulses
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= ST_IDLE;
         done_r  <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         done_r  <= (state_r == ST_LOAD);
         err_r   <= reject_s;
      end
   end

   // Shadow capture on accepted writes; shadow-to-active copy during LOAD
   always_ff @(posedge clock) begin
      if (reset) begin
         sh_brp_r    <= {BRP_W{1'b0}};
         sh_tseg1_r  <= {TSEG1_W{1'b0}};
         sh_tseg2_r  <= {TSEG2_W{1'b0}};
         sh_sjw_r    <= {SJW_W{1'b0}};
         act_brp_r   <= {BRP_W{1'b0}};
         act_tseg1_r <= {TSEG1_W{1'b0}};
         act_tseg2_r <= {TSEG2_W{1'b0}};
         act_sjw_r   <= {SJW_W{1'b0}};
         valid_r     <= 1'b0;
      end else begin
         if (capture_s) begin
            sh_brp_r   <= cfg_brp;
            sh_tseg1_r <= cfg_tseg1;
            sh_tseg2_r <= cfg_tseg2;
            sh_sjw_r   <= cfg_sjw;
         end
         if (state_r == ST_LOAD) begin
            act_brp_r   <= sh_brp_r;
            act_tseg1_r <= sh_tseg1_r;
            act_tseg2_r <= sh_tseg2_r;
            act_sjw_r   <= sh_sjw_r;
            valid_r     <= 1'b1;
         end
      end
   end

   assign in_run_s = (state_r == ST_RUN) || (state_r == ST_PEND);
   assign clear_s  = (state_nxt_s != ST_RUN) && (state_nxt_s != ST_PEND);

   bt_prescaler #(
      .BRP_W (BRP_W)
   ) u_prescaler (
      .clock       (clock),
      .reset       (reset),
      .clear       (clear_s),
      .run         (in_run_s),
      .brp         (act_brp_r),
      .Prescale_EN (pe_s)
   );

   assign Prescale_EN = pe_s;
   assign tseg1       = act_tseg1_r;
   assign tseg2       = act_tseg2_r;
   assign sjw         = act_sjw_r;
   assign cfg_valid   = valid_r;
   assign cfg_busy    = (state_r == ST_LOAD) || (state_r == ST_PEND);
   assign cfg_done    = done_r;
   assign cfg_err     = err_r;
   assign ctrl_st     = state_r;

endmodule

// File: tb/tb_bittiming_ctrl.sv
// Scoreboard bench: a cycle-level reference model predicts every output; a monitor compares.
module tb_bittiming_ctrl;

   localparam int BRP_W = 6;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             enable = 1'b0;
   logic             cfg_wr = 1'b0;
   logic [BRP_W-1:0] cfg_brp = '0;
   logic [3:0]       cfg_tseg1 = '0;
   logic [2:0]       cfg_tseg2 = '0;
   logic [1:0]       cfg_sjw = '0;
   logic             sendpoint = 1'b0;
   logic             Prescale_EN;
   logic [3:0]       tseg1;
   logic [2:0]       tseg2;
   logic [1:0]       sjw;
   logic             cfg_valid, cfg_busy, cfg_done, cfg_err;
   logic [1:0]       ctrl_st;

   typedef struct packed {
      logic       pe;
      logic [3:0] t1;
      logic [2:0] t2;
      logic [1:0] sj;
      logic       valid;
      logic       busy;
      logic       done;
      logic       err;
      logic [1:0] st;
   } obs_t;

   obs_t exp_q[$];
   obs_t exp_o, act_o;
   int   checks = 0;
   int   passed = 0;
   int   cyc = 0;

   // Reference model: mode uses the documented codes 0=IDLE 1=LOAD 2=RUN 3=PEND
   int m_mode = 0, m_valid = 0, m_runc = 0;
   int m_sh_brp = 0, m_sh_t1 = 0, m_sh_t2 = 0, m_sh_sj = 0;
   int m_act_brp = 0, m_act_t1 = 0, m_act_t2 = 0, m_act_sj = 0;
   bit m_done = 0, m_err = 0;

   always #5 clock = ~clock;

   bittiming_ctrl #(.BRP_W(BRP_W)) dut (
      .clock       (clock),
      .reset       (reset),
      .enable      (enable),
      .cfg_wr      (cfg_wr),
      .cfg_brp     (cfg_brp),
      .cfg_tseg1   (cfg_tseg1),
      .cfg_tseg2   (cfg_tseg2),
      .cfg_sjw     (cfg_sjw),
      .sendpoint   (sendpoint),
      .Prescale_EN (Prescale_EN),
      .tseg1       (tseg1),
      .tseg2       (tseg2),
      .sjw         (sjw),
      .cfg_valid   (cfg_valid),
      .cfg_busy    (cfg_busy),
      .cfg_done    (cfg_done),
      .cfg_err     (cfg_err),
      .ctrl_st     (ctrl_st)
   );

   // A quantum ends on the last clock of every (brp+1)-clock window since the counter restarted
   function automatic bit model_pe();
      return (m_mode == 2 || m_mode == 3) && ((m_runc % (m_act_brp + 1)) == m_act_brp);
   endfunction

   task automatic model_step();
      obs_t e;
      int   nmode;
      bit   ok, cur_pe, running;
      if (reset) begin
         m_mode = 0; m_valid = 0; m_runc = 0;
         m_sh_brp = 0; m_sh_t1 = 0; m_sh_t2 = 0; m_sh_sj = 0;
         m_act_brp = 0; m_act_t1 = 0; m_act_t2 = 0; m_act_sj = 0;
         m_done = 0; m_err = 0;
      end else begin
         ok = (int'(cfg_tseg2) != 0) && (int'(cfg_sjw) <= int'(cfg_tseg2)) &&
              (int'(cfg_tseg1) >= int'(cfg_sjw));
         cur_pe  = model_pe();
         running = (m_mode == 2 || m_mode == 3);
         m_err   = cfg_wr && (!ok || m_mode == 1 || m_mode == 3);
         m_done  = (m_mode == 1);
         nmode   = m_mode;
         if ((m_mode == 0 || m_mode == 2) && cfg_wr && ok) begin
            m_sh_brp = int'(cfg_brp); m_sh_t1 = int'(cfg_tseg1);
            m_sh_t2 = int'(cfg_tseg2); m_sh_sj = int'(cfg_sjw);
         end
         case (m_mode)
            0: if (cfg_wr && ok) nmode = 1; else if (enable && m_valid != 0) nmode = 2;
            1: begin
               m_act_brp = m_sh_brp; m_act_t1 = m_sh_t1; m_act_t2 = m_sh_t2; m_act_sj = m_sh_sj;
               m_valid = 1;
               nmode = enable ? 2 : 0;
            end
            2: if (cfg_wr && ok) nmode = enable ? 3 : 1; else if (!enable) nmode = 0;
            3: if (!enable || (sendpoint && cur_pe)) nmode = 1;
            default: nmode = 0;
         endcase
         m_runc = (running && (nmode == 2 || nmode == 3)) ? m_runc + 1 : 0;
         m_mode = nmode;
      end
      e.pe    = model_pe();
      e.t1    = 4'(m_act_t1);
      e.t2    = 3'(m_act_t2);
      e.sj    = 2'(m_act_sj);
      e.valid = (m_valid != 0);
      e.busy  = (m_mode == 1 || m_mode == 3);
      e.done  = m_done;
      e.err   = m_err;
      e.st    = 2'(m_mode);
      exp_q.push_back(e);
   endtask

   task automatic tick();
      model_step();
      @(negedge clock);
      cyc++;
   endtask

   task automatic apply(input bit r, input bit en, input bit wr, input int b,
                        input int t1, input int t2, input int sj, input bit sp);
      reset = r; enable = en; cfg_wr = wr; sendpoint = sp;
      cfg_brp = BRP_W'(b); cfg_tseg1 = 4'(t1); cfg_tseg2 = 3'(t2); cfg_sjw = 2'(sj);
      tick();
      cfg_wr = 1'b0;
      reset  = 1'b0;
   endtask

   task automatic run(input int n);
      cfg_wr = 1'b0;
      reset  = 1'b0;
      repeat (n) tick();
   endtask

   // Monitor: every clock the DUT presents one observation to match the oldest prediction
   always @(posedge clock) begin
      #1;
      if (exp_q.size() > 0) begin
         exp_o = exp_q.pop_front();
         act_o = {Prescale_EN, tseg1, tseg2, sjw, cfg_valid, cfg_busy, cfg_done, cfg_err, ctrl_st};
         checks++;
         if (act_o === exp_o) passed++;
         else $display("FAIL obs cyc=%0d got pe=%b t1=%0d t2=%0d sjw=%0d v=%b busy=%b done=%b err=%b st=%0d required pe=%b t1=%0d t2=%0d sjw=%0d v=%b busy=%b done=%b err=%b st=%0d",
                       cyc, act_o.pe, act_o.t1, act_o.t2, act_o.sj, act_o.valid, act_o.busy,
                       act_o.done, act_o.err, act_o.st, exp_o.pe, exp_o.t1, exp_o.t2, exp_o.sj,
                       exp_o.valid, exp_o.busy, exp_o.done, exp_o.err, exp_o.st);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got cyc=%0d required completion", cyc);
      $fatal(1);
   end

   initial begin
      // reset, then rejected writes while idle
      apply(1, 0, 0, 0, 0, 0, 0, 0);
      apply(1, 0, 0, 0, 0, 0, 0, 0);
      apply(0, 0, 1, 5, 5, 0, 0, 0);
      run(2);
      apply(0, 0, 1, 5, 5, 2, 3, 0);
      run(3);
      // first configuration, running with brp=3
      apply(0, 1, 1, 3, 5, 3, 1, 0);
      run(14);
      // update to brp=1 held pending until a bit boundary
      apply(0, 1, 1, 1, 6, 2, 2, 0);
      run(20);
      sendpoint = 1'b1;
      run(6);
      sendpoint = 1'b0;
      run(8);
      // second write while pending is rejected, the first is applied
      apply(0, 1, 1, 2, 7, 4, 1, 0);
      run(3);
      apply(0, 1, 1, 5, 3, 3, 3, 0);
      run(2);
      sendpoint = 1'b1;
      run(8);
      sendpoint = 1'b0;
      run(6);
      // disable while pending applies the value and idles
      apply(0, 1, 1, 0, 4, 2, 2, 0);
      run(2);
      enable = 1'b0;
      run(4);
      enable = 1'b1;
      run(5);
      // reset while running with brp=0
      apply(1, 1, 0, 0, 0, 0, 0, 0);
      run(3);
      // randomized traffic
      enable = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         reset = ($urandom_range(0, 127) == 0);
         if ($urandom_range(0, 31) == 0) enable = ~enable;
         cfg_wr = ($urandom_range(0, 11) == 0);
         if ($urandom_range(0, 7) == 0) cfg_brp = {BRP_W{1'b1}};
         else cfg_brp = BRP_W'($urandom_range(0, 5));
         cfg_tseg1 = 4'($urandom_range(0, 15));
         cfg_tseg2 = 3'($urandom_range(0, 7));
         cfg_sjw   = 2'($urandom_range(0, 3));
         sendpoint = ($urandom_range(0, 3) == 0);
         tick();
      end
      cfg_wr = 1'b0;
      reset  = 1'b0;
      @(posedge clock);
      #3;
      checks++;
      if (exp_q.size() == 0) passed++;
      else $display("FAIL drain: got %0d pending predictions, required 0", exp_q.size());
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
